// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/load-store request ports and shared single-port memory bus.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_flush;
  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] mem_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] if_rdata;
  logic [15:0] dm_rdata;
  logic        if_valid;
  logic        dm_valid;
  logic        if_stall;
  logic        dm_stall;
  modport master (
    output if_req, if_addr, if_flush, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, if_rdata, dm_rdata,
           if_valid, dm_valid, if_stall, dm_stall
  );
  modport slave (
    input  if_req, if_addr, if_flush, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, if_rdata, dm_rdata,
           if_valid, dm_valid, if_stall, dm_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and
// load/store, data first, one access every LATENCY+2 cycles.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, INST, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic        if_valid_q, if_valid_d, dm_valid_q, dm_valid_d, flush_q, flush_d;
  logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d, if_prev_q, if_prev_d, dm_rdata_q, dm_rdata_d;
  logic        dm_req, last, drop;
  always_comb begin
    dm_req      = bus.dm_rd | bus.dm_wr;
    last        = cnt_q == 4'd1;
    drop        = if_valid_q & bus.if_flush;
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_prev_d   = if_prev_q;
    dm_rdata_d  = dm_rdata_q;
    flush_d     = flush_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (dm_req) begin
          state_d     = DATA;
          cnt_d       = 4'(LATENCY);
          mem_en_d    = 1'b1;
          mem_wr_d    = bus.dm_wr;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
        end else if (bus.if_req) begin
          state_d    = INST;
          cnt_d      = 4'(LATENCY);
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = bus.if_addr;
        end
      end
      DATA: begin
        cnt_d = cnt_q - 4'd1;
        if (last) begin
          state_d    = DONE;
          mem_en_d   = 1'b0;
          dm_valid_d = 1'b1;
          dm_rdata_d = mem_wr_q ? dm_rdata_q : bus.mem_rdata;
        end
      end
      INST: begin
        cnt_d   = cnt_q - 4'd1;
        flush_d = flush_q | bus.if_flush;
        if (last) begin
          state_d  = DONE;
          mem_en_d = 1'b0;
          if (!flush_d) begin
            if_valid_d = 1'b1;
            if_prev_d  = if_rdata_q;
            if_rdata_d = bus.mem_rdata;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        if_rdata_d = drop ? if_prev_q : if_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_prev_q   <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_prev_q   <= if_prev_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      flush_q     <= flush_d;
    end
  end
  // A flush arriving in the completion cycle retracts the pulse and shows the prior word
  assign bus.if_valid  = if_valid_q & ~bus.if_flush;
  assign bus.if_rdata  = drop ? if_prev_q : if_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_stall  = bus.if_req & ~bus.if_valid;
  assign bus.dm_stall  = dm_req & ~dm_valid_q;
endmodule
